// File: rtl/aes_de_core_if.sv
// Host/key-store handshake bundle for the AES-128 decryption core.
// The core side uses the slave modport; whoever drives enable, ciphertext and keys uses master.
interface aes_de_core_if #(
    parameter int NO_ROWS = 4,
    parameter int NO_COLS = 4
) ();
    logic                                 aes_core_en;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_text_i;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] round_key_i;
    logic                                 key_vld_i;
    logic                                 key_req_o;
    logic [3:0]                           key_sel_o;
    logic                                 plain_text_rdy_o;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] plain_text_o;

    modport slave (
        input  aes_core_en, cipher_text_i, round_key_i, key_vld_i,
        output key_req_o, key_sel_o, plain_text_rdy_o, plain_text_o
    );

    modport master (
        output aes_core_en, cipher_text_i, round_key_i, key_vld_i,
        input  key_req_o, key_sel_o, plain_text_rdy_o, plain_text_o
    );
endinterface

// File: rtl/aes_de_core.sv
// Iterative AES-128 decryption core: one inverse round per accepted round key,
// requesting keys 10 down to 0 from an external key store.
module aes_de_core #(
    parameter int NO_ROWS = 4,
    parameter int NO_COLS = 4
) (
    input  logic         aes_clk,
    input  logic         resetn,
    aes_de_core_if.slave bus
);
    typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_t;
    typedef enum logic [1:0] {IDLE, KEY, DONE} fsm_e;

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (09/0b/0d/0e) as a sum of x, 2x, 4x, 8x.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    fsm_e       fsm_q, fsm_d;
    mat_t       blk_q, blk_d;
    mat_t       pt_q, pt_d;
    logic       keyReq_q, keyReq_d;
    logic [3:0] keySel_q, keySel_d;
    logic       ptRdy_q, ptRdy_d;

    mat_t shifted, subbed, keyed, mixed;
    logic accept;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        for (int r = 0; r < NO_ROWS; r++) begin
            for (int c = 0; c < NO_COLS; c++) begin
                shifted[r][(c + r) % NO_COLS] = blk_q[r][c];
            end
        end
        for (int r = 0; r < NO_ROWS; r++) begin
            for (int c = 0; c < NO_COLS; c++) begin
                subbed[r][c] = INV_SBOX[shifted[r][c]];
            end
        end
        keyed = subbed ^ bus.round_key_i;
        for (int c = 0; c < NO_COLS; c++) begin
            mixed[0][c] = gmul(keyed[0][c], 4'he) ^ gmul(keyed[1][c], 4'hb) ^ gmul(keyed[2][c], 4'hd) ^ gmul(keyed[3][c], 4'h9);
            mixed[1][c] = gmul(keyed[0][c], 4'h9) ^ gmul(keyed[1][c], 4'he) ^ gmul(keyed[2][c], 4'hb) ^ gmul(keyed[3][c], 4'hd);
            mixed[2][c] = gmul(keyed[0][c], 4'hd) ^ gmul(keyed[1][c], 4'h9) ^ gmul(keyed[2][c], 4'he) ^ gmul(keyed[3][c], 4'hb);
            mixed[3][c] = gmul(keyed[0][c], 4'hb) ^ gmul(keyed[1][c], 4'hd) ^ gmul(keyed[2][c], 4'h9) ^ gmul(keyed[3][c], 4'he);
        end
    end

    // Dropping the enable in KEY wins over a key arriving on the same edge.
    always_comb begin
        fsm_d    = fsm_q;
        blk_d    = blk_q;
        pt_d     = pt_q;
        keyReq_d = keyReq_q;
        keySel_d = keySel_q;
        ptRdy_d  = ptRdy_q;
        accept   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.aes_core_en) begin
                    blk_d    = bus.cipher_text_i;
                    keySel_d = 4'd10;
                    keyReq_d = 1'b1;
                    fsm_d    = KEY;
                end
            end
            KEY: begin
                if (!bus.aes_core_en) begin
                    keyReq_d = 1'b0;
                    keySel_d = 4'd0;
                    ptRdy_d  = 1'b0;
                    fsm_d    = IDLE;
                end else begin
                    accept = keyReq_q & bus.key_vld_i;
                    if (accept) begin
                        if (keySel_q == 4'd10) begin
                            blk_d    = blk_q ^ bus.round_key_i;
                            keySel_d = keySel_q - 4'd1;
                        end else if (keySel_q == 4'd0) begin
                            pt_d     = keyed;
                            ptRdy_d  = 1'b1;
                            keyReq_d = 1'b0;
                            fsm_d    = DONE;
                        end else begin
                            blk_d    = mixed;
                            keySel_d = keySel_q - 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (!bus.aes_core_en) begin
                    ptRdy_d = 1'b0;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q    <= IDLE;
            blk_q    <= '0;
            pt_q     <= '0;
            keyReq_q <= 1'b0;
            keySel_q <= 4'd0;
            ptRdy_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            blk_q    <= blk_d;
            pt_q     <= pt_d;
            keyReq_q <= keyReq_d;
            keySel_q <= keySel_d;
            ptRdy_q  <= ptRdy_d;
        end
    end

    assign bus.key_req_o        = keyReq_q;
    assign bus.key_sel_o        = keySel_q;
    assign bus.plain_text_rdy_o = ptRdy_q;
    assign bus.plain_text_o     = pt_q;
endmodule
